// File: rtl/monitor_pkg.sv
// Shared encodings for the gen2 logic-analyser monitor: bus regions, register map,
// CTRL bit positions and the capture / slave-sequencer state encodings.
package monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } la_state_t;

  typedef enum logic [2:0] {
    SQ_IDLE  = 3'd0,
    SQ_RAM   = 3'd1,
    SQ_RAM_Q = 3'd2,
    SQ_RESP  = 3'd3,
    SQ_WAIT  = 3'd4
  } seq_state_t;

  localparam logic [1:0] REGION_RAM  = 2'd0;
  localparam logic [1:0] REGION_REGS = 2'd1;
  localparam logic [1:0] REGION_EXT2 = 2'd2;
  localparam logic [1:0] REGION_EXT3 = 2'd3;

  localparam logic [4:0] OFF_STATUS    = 5'd0;
  localparam logic [4:0] OFF_CTRL      = 5'd1;
  localparam logic [4:0] OFF_TRIG_VAL  = 5'd2;
  localparam logic [4:0] OFF_TRIG_MASK = 5'd3;
  localparam logic [4:0] OFF_POST_CNT  = 5'd4;
  localparam logic [4:0] OFF_PTRS      = 5'd5;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_MODE  = 2;

  localparam logic MODE_CONT = 1'b0;
  localparam logic MODE_TRIG = 1'b1;

endpackage

// File: rtl/la_sample_ram.sv
// Simple dual-port sample buffer with a one-cycle registered read.
// A read and write of the same word in one cycle returns the old contents.
module la_sample_ram #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/monitor_la_gen2.sv
// Gen2 monitor: pattern/mask triggered capture of Monitored_Signals into a ring buffer,
// with registers and oldest-first sample readout on a CARDSEL/WR_N/SACK_N slave port.
module monitor_la_gen2
  import monitor_pkg::*;
#(
  parameter int         CH_W     = 32,
  parameter int         DEPTH_LG = 5,
  parameter logic [7:0] ID_NUM   = 8'h2A
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            step_en,
  input  logic            in_init,
  input  logic            stop_n,
  input  logic [CH_W-1:0] Monitored_Signals,
  input  logic            CARDSEL,
  input  logic            WR_N,
  input  logic [9:0]      AI,
  input  logic [31:0]     SDI,
  input  logic [31:0]     ext_in_2,
  input  logic [31:0]     ext_in_3,
  output logic            SACK_N,
  output logic [31:0]     SDO,
  output logic [4:0]      reg_address,
  output logic            armed
);

  localparam int DEPTH = 2**DEPTH_LG;
  localparam int CW    = DEPTH_LG + 1;

  la_state_t           state_reg, state_next;
  logic [DEPTH_LG-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LG-1:0] trig_ptr_reg, trig_ptr_next;
  logic [DEPTH_LG-1:0] post_left_reg, post_left_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                triggered_reg, triggered_next;
  logic                overflow_reg, overflow_next;
  logic                mode_reg, mode_next;
  logic [31:0]         trig_val_reg, trig_val_next;
  logic [31:0]         trig_mask_reg, trig_mask_next;
  logic [DEPTH_LG-1:0] post_cnt_reg, post_cnt_next;

  seq_state_t  seq_reg, seq_next;
  logic [7:0]  ai_off_reg, ai_off_next;
  logic        wr_n_reg, wr_n_next;
  logic [31:0] rd_hold_reg, rd_hold_next;
  logic        in_range_reg, in_range_next;
  logic [31:0] sdo_reg, sdo_next;
  logic        sack_n_reg, sack_n_next;
  logic [4:0]  reg_address_reg, reg_address_next;

  logic                samp, capturing, full, hit;
  logic                host_wr, reg_wr, ctrl_wr, ram_we;
  logic [31:0]         reg_rdata;
  logic [DEPTH_LG-1:0] base, ram_rd_addr;
  logic [CH_W-1:0]     ram_q;
  logic [31:0]         ram_word;

  assign samp      = step_en & ~in_init & stop_n;
  assign capturing = samp && (state_reg == ST_ARMED || state_reg == ST_POST);
  assign full      = (cnt_reg == CW'(DEPTH));
  assign hit       = ((Monitored_Signals ^ trig_val_reg[CH_W-1:0]) & trig_mask_reg[CH_W-1:0]) == '0;

  // Host writes commit on the edge where CARDSEL is first seen high.
  assign host_wr = (seq_reg == SQ_IDLE) && CARDSEL && !WR_N;
  assign reg_wr  = host_wr && (AI[9:8] == REGION_REGS);
  assign ctrl_wr = reg_wr && (AI[4:0] == OFF_CTRL);

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg;
    trig_ptr_next  = trig_ptr_reg;
    post_left_next = post_left_reg;
    cnt_next       = cnt_reg;
    triggered_next = triggered_reg;
    overflow_next  = overflow_reg;
    ram_we         = 1'b0;
    if (capturing) begin
      ram_we      = 1'b1;
      wr_ptr_next = wr_ptr_reg + 1'b1;
      if (full) overflow_next = 1'b1;
      else      cnt_next      = cnt_reg + 1'b1;
      case (state_reg)
        ST_ARMED: begin
          if (mode_reg == MODE_TRIG && hit) begin
            trig_ptr_next  = wr_ptr_reg;
            triggered_next = 1'b1;
            post_left_next = post_cnt_reg;
            state_next     = (post_cnt_reg == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          post_left_next = post_left_reg - 1'b1;
          if (post_left_reg == DEPTH_LG'(1)) state_next = ST_DONE;
        end
        default: ;
      endcase
    end
    // Arm and clear both restart the capture; clear wins when both are set.
    if (ctrl_wr && (SDI[CTRL_ARM] || SDI[CTRL_CLEAR])) begin
      ram_we         = 1'b0;
      wr_ptr_next    = '0;
      trig_ptr_next  = '0;
      post_left_next = '0;
      cnt_next       = '0;
      triggered_next = 1'b0;
      overflow_next  = 1'b0;
      state_next     = SDI[CTRL_CLEAR] ? ST_IDLE : ST_ARMED;
    end
  end

  always_comb begin
    mode_next      = mode_reg;
    trig_val_next  = trig_val_reg;
    trig_mask_next = trig_mask_reg;
    post_cnt_next  = post_cnt_reg;
    if (reg_wr) begin
      case (AI[4:0])
        OFF_CTRL:      mode_next      = SDI[CTRL_MODE];
        OFF_TRIG_VAL:  trig_val_next  = SDI;
        OFF_TRIG_MASK: trig_mask_next = SDI;
        OFF_POST_CNT:  post_cnt_next  = SDI[DEPTH_LG-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (AI[4:0])
      OFF_STATUS:    reg_rdata = {16'(cnt_reg), ID_NUM, 2'b00, overflow_reg, triggered_reg,
                                  full, mode_reg, state_reg};
      OFF_CTRL:      reg_rdata[CTRL_MODE] = mode_reg;
      OFF_TRIG_VAL:  reg_rdata = trig_val_reg;
      OFF_TRIG_MASK: reg_rdata = trig_mask_reg;
      OFF_POST_CNT:  reg_rdata = 32'(post_cnt_reg);
      OFF_PTRS:      reg_rdata = 32'({trig_ptr_reg, wr_ptr_reg});
      default: ;
    endcase
  end

  // Once the ring has wrapped, the oldest sample sits at wr_ptr.
  assign base        = full ? wr_ptr_reg : '0;
  assign ram_rd_addr = base + ai_off_reg[DEPTH_LG-1:0];

  la_sample_ram #(.W(CH_W), .AW(DEPTH_LG)) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_reg),
    .wr_data (Monitored_Signals),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_q)
  );

  for (genvar gi = 0; gi < 32; gi++) begin : g_ram_word
    if (gi < CH_W) begin : g_ch
      assign ram_word[gi] = ram_q[gi];
    end else begin : g_pad
      assign ram_word[gi] = 1'b0;
    end
  end

  always_comb begin
    seq_next         = seq_reg;
    ai_off_next      = ai_off_reg;
    wr_n_next        = wr_n_reg;
    rd_hold_next     = rd_hold_reg;
    in_range_next    = in_range_reg;
    sdo_next         = sdo_reg;
    sack_n_next      = sack_n_reg;
    reg_address_next = reg_address_reg;
    case (seq_reg)
      SQ_IDLE: begin
        if (CARDSEL) begin
          ai_off_next      = AI[7:0];
          wr_n_next        = WR_N;
          reg_address_next = AI[4:0];
          case (AI[9:8])
            REGION_REGS: rd_hold_next = reg_rdata;
            REGION_EXT2: rd_hold_next = ext_in_2;
            REGION_EXT3: rd_hold_next = ext_in_3;
            default:     rd_hold_next = '0;
          endcase
          seq_next = (WR_N && AI[9:8] == REGION_RAM) ? SQ_RAM : SQ_RESP;
        end
      end
      SQ_RAM: begin
        in_range_next = {1'b0, ai_off_reg} < 9'(cnt_reg);
        seq_next      = SQ_RAM_Q;
      end
      SQ_RAM_Q: begin
        sdo_next    = in_range_reg ? ram_word : '0;
        sack_n_next = 1'b0;
        seq_next    = SQ_WAIT;
      end
      SQ_RESP: begin
        if (wr_n_reg) sdo_next = rd_hold_reg;
        sack_n_next = 1'b0;
        seq_next    = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (!CARDSEL) begin
          sack_n_next = 1'b1;
          seq_next    = SQ_IDLE;
        end
      end
      default: seq_next = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      trig_ptr_reg  <= '0;
      post_left_reg <= '0;
      cnt_reg       <= '0;
      triggered_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      mode_reg      <= MODE_CONT;
      trig_val_reg  <= '0;
      trig_mask_reg <= '0;
      post_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      trig_ptr_reg  <= trig_ptr_next;
      post_left_reg <= post_left_next;
      cnt_reg       <= cnt_next;
      triggered_reg <= triggered_next;
      overflow_reg  <= overflow_next;
      mode_reg      <= mode_next;
      trig_val_reg  <= trig_val_next;
      trig_mask_reg <= trig_mask_next;
      post_cnt_reg  <= post_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_reg         <= SQ_IDLE;
      ai_off_reg      <= '0;
      wr_n_reg        <= 1'b1;
      rd_hold_reg     <= '0;
      in_range_reg    <= 1'b0;
      sdo_reg         <= '0;
      sack_n_reg      <= 1'b1;
      reg_address_reg <= '0;
    end else begin
      seq_reg         <= seq_next;
      ai_off_reg      <= ai_off_next;
      wr_n_reg        <= wr_n_next;
      rd_hold_reg     <= rd_hold_next;
      in_range_reg    <= in_range_next;
      sdo_reg         <= sdo_next;
      sack_n_reg      <= sack_n_next;
      reg_address_reg <= reg_address_next;
    end
  end

  assign SACK_N      = sack_n_reg;
  assign SDO         = sdo_reg;
  assign reg_address = reg_address_reg;
  assign armed       = (state_reg == ST_ARMED) || (state_reg == ST_POST);

endmodule

// File: tb/tb_monitor_la_gen2.sv
// Randomised bench for monitor_la_gen2 against a queue-based model of the capture
// buffer and register map; directed scenarios first, then a random mix.
module tb_monitor_la_gen2;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_en = 1'b0, in_init = 1'b0, stop_n = 1'b1;
  logic [31:0] Monitored_Signals = '0;
  logic        CARDSEL = 1'b0, WR_N = 1'b1;
  logic [9:0]  AI = '0;
  logic [31:0] SDI = '0, ext_in_2 = '0, ext_in_3 = '0;
  logic        SACK_N;
  logic [31:0] SDO;
  logic [4:0]  reg_address;
  logic        armed;

  int total = 0;
  int bad   = 0;

  monitor_la_gen2 #(.CH_W(32), .DEPTH_LG(5), .ID_NUM(8'h2A)) dut (
    .clk(clk), .reset(reset), .step_en(step_en), .in_init(in_init), .stop_n(stop_n),
    .Monitored_Signals(Monitored_Signals), .CARDSEL(CARDSEL), .WR_N(WR_N), .AI(AI),
    .SDI(SDI), .ext_in_2(ext_in_2), .ext_in_3(ext_in_3), .SACK_N(SACK_N), .SDO(SDO),
    .reg_address(reg_address), .armed(armed)
  );

  always #5 clk = ~clk;

  // Reference model: stored samples kept oldest-first in a bounded queue.
  logic [31:0] mq[$];
  int          m_state, m_total, m_trig_ptr, m_post_left;
  logic        m_mode, m_trig, m_ovf;
  logic [31:0] m_val, m_mask, m_sdo;
  logic [4:0]  m_post;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic void model_restart(input int st);
    mq.delete();
    m_total = 0; m_trig_ptr = 0; m_post_left = 0;
    m_trig = 1'b0; m_ovf = 1'b0; m_state = st;
  endfunction

  function automatic void model_reset();
    model_restart(0);
    m_mode = 1'b0; m_val = '0; m_mask = '0; m_post = '0; m_sdo = '0;
  endfunction

  function automatic void model_sample(input logic [31:0] v, input logic q);
    int idx;
    if (q && (m_state == 1 || m_state == 2)) begin
      if (mq.size() == DEPTH) begin
        m_ovf = 1'b1;
        void'(mq.pop_front());
      end
      mq.push_back(v);
      idx = m_total;
      m_total++;
      if (m_state == 1) begin
        if (m_mode && ((v ^ m_val) & m_mask) == 32'h0) begin
          m_trig = 1'b1;
          m_trig_ptr = idx % DEPTH;
          m_post_left = int'(m_post);
          m_state = (m_post == 5'd0) ? 3 : 2;
        end
      end else begin
        m_post_left--;
        if (m_post_left == 0) m_state = 3;
      end
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [9:0] addr);
    int k;
    logic [4:0] tp, wp;
    logic full;
    full = (mq.size() == DEPTH);
    tp = 5'(m_trig_ptr);
    wp = 5'(m_total % DEPTH);
    case (addr[9:8])
      2'd0: begin
        k = int'(addr[7:0]);
        return (k < mq.size()) ? mq[k] : 32'h0;
      end
      2'd1: begin
        case (addr[4:0])
          5'd0: return {16'(mq.size()), 8'h2A, 2'b00, m_ovf, m_trig, full, m_mode, 2'(m_state)};
          5'd1: return {29'b0, m_mode, 2'b00};
          5'd2: return m_val;
          5'd3: return m_mask;
          5'd4: return 32'(m_post);
          5'd5: return 32'({tp, wp});
          default: return 32'h0;
        endcase
      end
      2'd2: return ext_in_2;
      default: return ext_in_3;
    endcase
  endfunction

  function automatic void model_write(input logic [9:0] addr, input logic [31:0] data);
    if (addr[9:8] == 2'd1) begin
      case (addr[4:0])
        5'd1: begin
          m_mode = data[2];
          if (data[1]) model_restart(0);
          else if (data[0]) model_restart(1);
        end
        5'd2: m_val = data;
        5'd3: m_mask = data;
        5'd4: m_post = data[4:0];
        default: ;
      endcase
    end
  endfunction

  task automatic sample(input logic [31:0] v, input logic st, input logic ii, input logic sn);
    @(negedge clk);
    Monitored_Signals = v; step_en = st; in_init = ii; stop_n = sn;
    @(posedge clk);
    #1;
    step_en = 1'b0; in_init = 1'b0; stop_n = 1'b1;
    model_sample(v, st & ~ii & sn);
  endtask

  // One slave access; lat counts edges after E until SACK_N is seen low.
  task automatic host_access(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                             output logic [31:0] rdata, output int lat);
    int n;
    @(negedge clk);
    CARDSEL = 1'b1; WR_N = ~wr; AI = addr; SDI = data;
    n = 0;
    @(posedge clk);
    #1;
    while (SACK_N && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n;
    rdata = SDO;
    @(negedge clk);
    CARDSEL = 1'b0;
    @(posedge clk);
    #1;
    check("sack_release", 32'(SACK_N), 32'd1);
  endtask

  task automatic do_access(input string tag, input logic wr, input logic [9:0] addr,
                           input logic [31:0] data, output logic [31:0] got);
    logic [31:0] exp_d;
    int lat, exp_lat;
    exp_d   = wr ? m_sdo : model_read(addr);
    exp_lat = (!wr && addr[9:8] == 2'd0) ? 2 : 1;
    host_access(wr, addr, data, got, lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_sdo"}, got, exp_d);
    check({tag, "_regaddr"}, 32'(reg_address), 32'(addr[4:0]));
    if (wr) model_write(addr, data);
    else m_sdo = exp_d;
    $display("acc %s wr=%0b ai=%03h sdi=%08h sdo=%08h lat=%0d", tag, wr, addr, data, got, lat);
  endtask

  task automatic check_armed(input string tag);
    check(tag, 32'(armed), 32'(m_state == 1 || m_state == 2));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    logic [31:0] got;
    int r, n;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_sack", 32'(SACK_N), 32'd1);
    check("rst_sdo", SDO, 32'h0);
    check("rst_regaddr", 32'(reg_address), 32'h0);
    check("rst_armed", 32'(armed), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_access("t1_status", 1'b0, 10'h100, 32'h0, got);
    check("t1_status_const", got, 32'h0000_2A00);

    do_access("t2_arm", 1'b1, 10'h101, 32'h1, got);
    check("t2_sdo_hold", got, 32'h0000_2A00);
    for (int i = 0; i < 40; i++) sample(32'(i), 1'b1, 1'b0, 1'b1);
    check_armed("t2_armed");
    do_access("t2_status", 1'b0, 10'h100, 32'h0, got);
    check("t2_status_const", got, 32'h0020_2A29);
    do_access("t2_off0", 1'b0, 10'h000, 32'h0, got);
    check("t2_off0_const", got, 32'd8);
    do_access("t2_off31", 1'b0, 10'h01F, 32'h0, got);
    check("t2_off31_const", got, 32'd39);
    do_access("t2_off32", 1'b0, 10'h020, 32'h0, got);

    do_access("t3_val", 1'b1, 10'h102, 32'h0000_00A5, got);
    do_access("t3_mask", 1'b1, 10'h103, 32'h0000_00FF, got);
    do_access("t3_post", 1'b1, 10'h104, 32'd3, got);
    do_access("t3_arm", 1'b1, 10'h101, 32'h5, got);
    for (int i = 0; i < 180; i++) sample(32'(i), 1'b1, 1'b0, 1'b1);
    check_armed("t3_armed");
    do_access("t3_status", 1'b0, 10'h100, 32'h0, got);
    check("t3_status_const", got, 32'h0020_2A3F);
    do_access("t3_ptrs", 1'b0, 10'h105, 32'h0, got);
    check("t3_ptrs_const", got, 32'h0000_00A9);
    do_access("t3_newest", 1'b0, 10'h01F, 32'h0, got);
    check("t3_newest_const", got, 32'h0000_00A8);
    do_access("t3_ctrl", 1'b0, 10'h101, 32'h0, got);

    do_access("t4_mask0", 1'b1, 10'h103, 32'h0, got);
    do_access("t4_post0", 1'b1, 10'h104, 32'h0, got);
    do_access("t4_arm", 1'b1, 10'h101, 32'h5, got);
    for (int i = 0; i < 5; i++) sample(32'(i), 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) sample(32'(i), 1'b1, 1'b0, 1'b0);
    do_access("t4_status_q", 1'b0, 10'h100, 32'h0, got);
    check("t4_status_q_const", got, 32'h0000_2A05);
    sample(32'h7, 1'b1, 1'b0, 1'b1);
    do_access("t4_status_t", 1'b0, 10'h100, 32'h0, got);
    check("t4_status_t_const", got, 32'h0001_2A17);
    do_access("t4_off0", 1'b0, 10'h000, 32'h0, got);
    do_access("t4_off1", 1'b0, 10'h001, 32'h0, got);
    do_access("t4_ptrs", 1'b0, 10'h105, 32'h0, got);
    check("t4_ptrs_const", got, 32'h1);

    do_access("t5_mask", 1'b1, 10'h103, 32'hFF, got);
    do_access("t5_arm", 1'b1, 10'h101, 32'h5, got);
    for (int i = 0; i < 3; i++) sample(32'h0, 1'b1, 1'b0, 1'b1);
    do_access("t5_armclr", 1'b1, 10'h101, 32'h3, got);
    do_access("t5_status", 1'b0, 10'h100, 32'h0, got);
    check("t5_status_const", got, 32'h0000_2A00);
    check_armed("t5_armed");

    @(negedge clk);
    CARDSEL = 1'b1; WR_N = 1'b1; AI = 10'h102;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_sack", 32'(SACK_N), 32'd1);
    check("t5_rst_sdo", SDO, 32'h0);
    @(negedge clk);
    CARDSEL = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    $display("acc t5_reset_midread aborted");

    ext_in_2 = 32'hDEAD_BEEF;
    ext_in_3 = 32'h1234_5678;
    do_access("t6_ext2", 1'b0, 10'h200, 32'h0, got);
    check("t6_ext2_const", got, 32'hDEAD_BEEF);
    do_access("t6_ext3", 1'b0, 10'h37F, 32'h0, got);
    do_access("t6_wr_ext", 1'b1, 10'h205, 32'hFFFF_FFFF, got);
    do_access("t6_wr_unmapped", 1'b1, 10'h107, 32'hFFFF_FFFF, got);
    do_access("t6_unmapped", 1'b0, 10'h107, 32'h0, got);
    check("t6_unmapped_const", got, 32'h0);

    do_access("r_arm", 1'b1, 10'h101, 32'h1, got);
    for (int it = 0; it < 80; it++) begin
      r = int'($urandom_range(0, 9));
      if (r <= 3) begin
        n = int'($urandom_range(1, 20));
        for (int j = 0; j < n; j++)
          sample($urandom(), 1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 4) != 0));
      end else if (r == 4) begin
        do_access("r_ctrl", 1'b1, 10'h101, 32'($urandom_range(0, 7)), got);
      end else if (r == 5) begin
        case ($urandom_range(0, 2))
          0: do_access("r_val", 1'b1, 10'h102, 32'($urandom_range(0, 15)), got);
          1: do_access("r_mask", 1'b1, 10'h103, ($urandom_range(0, 1) != 0) ? 32'h3 : 32'hF, got);
          default: do_access("r_post", 1'b1, 10'h104, 32'($urandom_range(0, 31)), got);
        endcase
      end else if (r <= 8) begin
        do_access("r_ram", 1'b0, 10'($urandom_range(0, DEPTH + 3)), 32'h0, got);
      end else begin
        do_access("r_reg", 1'b0, 10'h100 | 10'($urandom_range(0, 7)), 32'h0, got);
      end
      check_armed("r_armed");
    end
    do_access("r_status", 1'b0, 10'h100, 32'h0, got);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
